// File: rtl/obi_arbiter_2to1_pkg.sv
// Shared host identifiers and helpers for the two-host OBI arbiter.
// HostIfetch/HostData are the instruction-fetch and data host IDs.
package obi_arbiter_2to1_pkg;

    typedef enum logic {
        HostIfetch = 1'b0,
        HostData   = 1'b1
    } host_e;

    // Round-robin pick: on a tie the host not granted last wins.
    function automatic host_e pick_host(input logic req0, input logic req1, input host_e last);
        if (req0 && req1) begin
            return (last == HostIfetch) ? HostData : HostIfetch;
        end else if (req1) begin
            return HostData;
        end
        return HostIfetch;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of 1-bit owner IDs for accepted-but-unanswered transactions.
// Synchronous active-low reset; pointers wrap modulo Depth.
module obi_id_fifo
    import obi_arbiter_2to1_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic            head,
    output logic [CntW-1:0] count
);

    localparam int unsigned PtrW = ptr_width(Depth);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/obi_arbiter_2to1.sv
// Round-robin 2:1 OBI arbiter sharing one memory port between ifetch (h0) and data (h1) hosts.
// Holds a pending request until granted and routes in-order responses via an owner-ID FIFO.
module obi_arbiter_2to1
    import obi_arbiter_2to1_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        h0_req_i,
    input  logic        h0_we_i,
    input  logic [7:0]  h0_be_i,
    input  logic [63:0] h0_addr_i,
    input  logic [63:0] h0_wdata_i,
    output logic        h0_gnt_o,
    output logic        h0_rvalid_o,
    output logic [63:0] h0_rdata_o,
    input  logic        h1_req_i,
    input  logic        h1_we_i,
    input  logic [7:0]  h1_be_i,
    input  logic [63:0] h1_addr_i,
    input  logic [63:0] h1_wdata_i,
    output logic        h1_gnt_o,
    output logic        h1_rvalid_o,
    output logic [63:0] h1_rdata_o,
    output logic        req_o,
    output logic        we_o,
    output logic [7:0]  be_o,
    output logic [63:0] addr_o,
    output logic [63:0] wdata_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [63:0] rdata_i,
    output logic        err_o
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    host_e           sel;
    host_e           last_q, last_d;
    host_e           lock_id_q, lock_id_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;
    logic            sel_req, req, accept;
    logic            rsp_valid, spurious, has_room;
    logic            fifo_full, fifo_empty, fifo_head;
    logic [CntW-1:0] fifo_count;

    always_comb begin
        sel = HostIfetch;
        if (lock_q) begin
            sel = lock_id_q;
        end else begin
            sel = pick_host(h0_req_i, h1_req_i, last_q);
        end
    end

    assign sel_req   = (sel == HostData) ? h1_req_i : h0_req_i;
    assign rsp_valid = rvalid_i && !fifo_empty;
    assign spurious  = rvalid_i && (fifo_count == '0);
    // A response popping the head frees a slot in the same cycle.
    assign has_room  = !fifo_full || rsp_valid;
    assign req       = sel_req && (lock_q || has_room);
    assign accept    = req && gnt_i;

    obi_id_fifo #(
        .Depth (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (accept),
        .push_id (sel),
        .pop     (rvalid_i),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        last_d    = last_q;
        if (accept) begin
            lock_d = 1'b0;
            last_d = sel;
        end else if (req) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end
        err_d = err_q || spurious;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= HostIfetch;
            last_q    <= HostIfetch;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        req_o       = 1'b0;
        we_o        = 1'b0;
        be_o        = '0;
        addr_o      = '0;
        wdata_o     = '0;
        h0_gnt_o    = 1'b0;
        h1_gnt_o    = 1'b0;
        h0_rvalid_o = 1'b0;
        h1_rvalid_o = 1'b0;
        h0_rdata_o  = '0;
        h1_rdata_o  = '0;
        err_o       = 1'b0;
        if (rst_ni) begin
            req_o       = req;
            we_o        = (sel == HostData) ? h1_we_i    : h0_we_i;
            be_o        = (sel == HostData) ? h1_be_i    : h0_be_i;
            addr_o      = (sel == HostData) ? h1_addr_i  : h0_addr_i;
            wdata_o     = (sel == HostData) ? h1_wdata_i : h0_wdata_i;
            h0_gnt_o    = accept && (sel == HostIfetch);
            h1_gnt_o    = accept && (sel == HostData);
            h0_rvalid_o = rsp_valid && (fifo_head == 1'b0);
            h1_rvalid_o = rsp_valid && (fifo_head == 1'b1);
            h0_rdata_o  = rdata_i;
            h1_rdata_o  = rdata_i;
            err_o       = err_q;
        end
    end

endmodule
